// File: rtl/normalizer_8bit_seq.sv
// Iterative normalizer: shifts a nonzero operand one bit per clock until its first set bit
// reaches the MSB (lr=1) or the LSB (lr=0). It reports the normalized value and the shift count.
module normalizer_8bit_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             lr,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] n,
  output logic             zero
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_reg, state_next;
  logic               dir_reg, dir_next;
  logic [WIDTH-1:0]   sreg_reg, sreg_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [WIDTH-1:0]   out_reg, out_next;
  logic [CNT_W-1:0]   n_reg, n_next;
  logic               zero_reg, zero_next;
  logic               target_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      dir_reg   <= 1'b0;
      sreg_reg  <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      out_reg   <= '0;
      n_reg     <= '0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      sreg_reg  <= sreg_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      out_reg   <= out_next;
      n_reg     <= n_next;
      zero_reg  <= zero_next;
    end
  end

  // The bit being searched for depends on the latched direction, not the live lr input.
  assign target_bit = dir_reg ? sreg_reg[WIDTH-1] : sreg_reg[0];

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    sreg_next  = sreg_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    out_next   = out_reg;
    n_next     = n_reg;
    zero_next  = zero_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          dir_next = lr;
          if (in == '0) begin
            // An all-zero operand has no target bit, so it completes immediately.
            out_next  = '0;
            n_next    = '0;
            zero_next = 1'b1;
            done_next = 1'b1;
          end else begin
            sreg_next  = in;
            cnt_next   = '0;
            busy_next  = 1'b1;
            zero_next  = 1'b0;
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (target_bit) begin
          out_next   = sreg_reg;
          n_next     = cnt_reg;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          sreg_next = dir_reg ? (sreg_reg << 1) : (sreg_reg >> 1);
          cnt_next  = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign out  = out_reg;
  assign n    = n_reg;
  assign zero = zero_reg;

endmodule

// File: tb/tb_normalizer_8bit_seq.sv
// Directed and exhaustive checks for normalizer_8bit_seq. Inputs are driven and outputs are
// sampled on the falling edge, and the DUT acts on the rising edge.
module tb_normalizer_8bit_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       lr;
  logic [7:0] in;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic [2:0] n;
  logic       zero;

  int checks = 0;
  int errors = 0;

  normalizer_8bit_seq #(.WIDTH(8), .CNT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .lr    (lr),
    .in    (in),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .n     (n),
    .zero  (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // lat counts falling edges from E0. lat=1 means done is visible right after E0, and lat=k
  // means done is visible after edge E0+(k-1). A nonzero operand needs n+2, and a zero operand needs 1.
  task automatic run_op(input string tag, input logic l, input logic [7:0] v,
                        input logic [7:0] exp_out, input logic [2:0] exp_n, input logic exp_zero,
                        output logic [7:0] got_out, output logic [2:0] got_n);
    int lat;
    int busy_cyc;
    int exp_lat;
    @(negedge clk);
    start = 1'b1;
    lr    = l;
    in    = v;
    @(posedge clk);
    lat      = 0;
    busy_cyc = 0;
    do begin
      @(negedge clk);
      if (lat == 0) start = 1'b0;
      lat++;
      if (done) break;
      if (busy) busy_cyc++;
    end while (lat < 20);
    got_out = out;
    got_n   = n;
    exp_lat = exp_zero ? 1 : int'(exp_n) + 2;
    $display("op %s lr=%0d in=%b -> out=%b n=%0d zero=%0d lat=%0d busy_cycles=%0d",
             tag, l, v, out, n, zero, lat, busy_cyc);
    check({tag, "_lat"},  lat,      exp_lat);
    check({tag, "_busy"}, busy_cyc, exp_lat - 1);
    check({tag, "_out"},  out,      exp_out);
    check({tag, "_n"},    n,        exp_n);
    check({tag, "_zero"}, zero,     exp_zero);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_width"}, done, 1'b0);
  endtask

  initial begin
    logic [7:0] o;
    logic [2:0] k;
    logic [7:0] vv;
    logic [7:0] eout;
    logic [7:0] back;
    int         en;
    int         pulses;
    int         wide;
    int         cyc;
    logic       prev_done;

    rst   = 1'b0;
    start = 1'b0;
    lr    = 1'b0;
    in    = 8'h00;
    #1 rst = 1'b1;
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out",  out,  8'h00);
    check("rst_n",    n,    3'd0);
    check("rst_zero", zero, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors from the test plan.
    run_op("left_0x16",  1'b1, 8'b00010110, 8'b10110000, 3'd3, 1'b0, o, k);
    run_op("right_0xd6", 1'b0, 8'b11010110, 8'b01101011, 3'd1, 1'b0, o, k);
    run_op("right_0x80", 1'b0, 8'b10000000, 8'b00000001, 3'd7, 1'b0, o, k);
    run_op("left_0x80",  1'b1, 8'b10000000, 8'b10000000, 3'd0, 1'b0, o, k);
    run_op("left_0x01",  1'b1, 8'b00000001, 8'b10000000, 3'd7, 1'b0, o, k);
    run_op("zero_l1",    1'b1, 8'h00,       8'h00,       3'd0, 1'b1, o, k);
    run_op("right_0x01", 1'b0, 8'b00000001, 8'b00000001, 3'd0, 1'b0, o, k);
    run_op("zero_l0",    1'b0, 8'h00,       8'h00,       3'd0, 1'b1, o, k);

    // A second start during SHIFT must not disturb the operation in flight.
    @(negedge clk);
    start = 1'b1; lr = 1'b1; in = 8'b00000001;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; lr = 1'b0; in = 8'hFF;
    @(negedge clk);
    start = 1'b0; in = 8'h3C;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    $display("op midstart lr=1 in=00000001 -> out=%b n=%0d zero=%0d", out, n, zero);
    check("midstart_done", done, 1'b1);
    check("midstart_out",  out,  8'b10000000);
    check("midstart_n",    n,    3'd7);
    check("midstart_zero", zero, 1'b0);
    @(negedge clk);
    check("midstart_idle", busy, 1'b0);

    // With start held high, 01000000 (n=1) repeats every 3 edges, giving 6 done pulses in 18 cycles.
    @(negedge clk);
    start = 1'b1; lr = 1'b1; in = 8'b01000000;
    @(posedge clk);
    pulses = 0; wide = 0; prev_done = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (prev_done) wide++;
        check("held_out", out, 8'b10000000);
      end
      prev_done = done;
    end
    start = 1'b0;
    $display("op held_start lr=1 in=01000000 -> pulses=%0d wide=%0d", pulses, wide);
    check("held_pulses", pulses, 6);
    check("held_wide",   wide,   0);
    repeat (4) @(negedge clk);

    // Assert reset asynchronously during an operation, after a nonzero result is held.
    run_op("pre_rst", 1'b1, 8'b00010110, 8'b10110000, 3'd3, 1'b0, o, k);
    @(negedge clk);
    start = 1'b1; lr = 1'b1; in = 8'b00000001;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("op async_reset mid-shift -> busy=%0d done=%0d out=%b n=%0d", busy, done, out, n);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_out",  out,  8'h00);
    check("arst_n",    n,    3'd0);
    check("arst_zero", zero, 1'b0);
    @(negedge clk);
    #3 rst = 1'b0;
    run_op("post_rst", 1'b0, 8'b11010110, 8'b01101011, 3'd1, 1'b0, o, k);

    // Sweep every nonzero operand in both directions against a reference model.
    for (int v = 1; v < 256; v++) begin
      for (int d = 0; d < 2; d++) begin
        vv = v[7:0];
        en = 0;
        if (d == 1) begin
          for (int i = 0; i < 8; i++) if (vv[i]) en = 7 - i;
          eout = vv << en;
        end else begin
          for (int i = 7; i >= 0; i--) if (vv[i]) en = i;
          eout = vv >> en;
        end
        run_op("sweep", d[0], vv, eout, en[2:0], 1'b0, o, k);
        check("sweep_target", (d == 1) ? o[7] : o[0], 1'b1);
        back = (d == 1) ? (o >> k) : (o << k);
        check("sweep_back", back, vv);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
